dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter sharing the single-ported, synchronous-read `data_mem` between the core load/store unit (port 0) and a secondary master such as a loader or debug port (port 1). It selects one request per cycle, drives the memory's address, write-data and byte-enable inputs, and routes the registered read data back to the requester that issued the read. It also keeps a saturating contention counter for performance analysis.

## Interface
Parameters:
- `DATA_WIDTH`, 64, data bus width.
- `ADDR_WIDTH`, `DATA_WIDTH`, byte address width.
- `DATA_BYTES`, `DATA_WIDTH/8`, byte-enable width.
- `CNT_WIDTH`, 32, contention counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_req0` / `i_req1`  in  1  request from port 0 / port 1.
- `i_addr0` / `i_addr1`  in  `ADDR_WIDTH`  byte address.
- `i_wdata0` / `i_wdata1`  in  `DATA_WIDTH`  write data.
- `i_wen0` / `i_wen1`  in  `DATA_BYTES`  byte enables; all-zero means read.
- `o_gnt0` / `o_gnt1`  out  1  request accepted this cycle.
- `o_rvalid0` / `o_rvalid1`  out  1  read data valid.
- `o_rdata0` / `o_rdata1`  out  `DATA_WIDTH`  read data.
- `o_mem_addr`  out  `ADDR_WIDTH`  to memory `i_addr`.
- `o_mem_wdata`  out  `DATA_WIDTH`  to memory `i_wdata`.
- `o_mem_wen`  out  `DATA_BYTES`  to memory `i_wen`.
- `i_mem_rdata`  in  `DATA_WIDTH`  from memory `o_rdata`.
- `o_conflicts`  out  `CNT_WIDTH`  count of cycles with both requests asserted.

## Operation
- Handshake: a requester holds its request and payload stable until it sees grant in the same cycle. At most one grant is asserted per cycle. Grant is combinational from the requests and the arbitration state.
- Memory drive: when a grant is issued, the memory outputs carry the granted port's address, write data and byte enables. With no grant, `o_mem_wen` is 0 and address/data hold port 0's values (no write occurs).
- Response routing: a granted read (byte enables all zero) sets `resp_vld`, and `resp_port` records the granting port. In the next cycle the matching `o_rvalidN` is 1 and `o_rdataN` equals `i_mem_rdata`. The other port's `o_rdata` is driven as 0.
- Writes produce no response. Memory write-first semantics hold: a read of the same address in the following cycle returns the new data.
- Arbitration: fixed priority, or round-robin when `DMEM_ARB_RR_EN` is defined (see Configuration).
- Contention counter: `o_conflicts` increments on every cycle with both requests asserted and saturates at all-ones. It has no wrap-around.
- Full pipelining: one grant per cycle, with no bubble between back-to-back reads from the same or different ports.

## Timing
- Reset values: `o_gnt*`=0, `o_rvalid*`=0, `o_rdata*`=0, `o_mem_wen`=0, `o_conflicts`=0, round-robin pointer = port 0 preferred.
- While `rst_n` is low, both grants are forced to 0.
- Read latency: grant in cycle N gives rvalid in cycle N+1, exactly one cycle wide.
- Reset asserted while a read is outstanding: the response is dropped and `o_rvalid*` is 0 after reset releases.
- Simultaneous events: a new grant in cycle N+1 coexists with the response to cycle N. The two may belong to different ports.
- Sim-control addresses (0x40, 0x50) and the cycle-read address (0x60) pass through unmodified. The arbiter does not decode addresses.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration.
  - On conflict, the port indicated by the pointer wins.
  - After any grant, the pointer moves to the other port.
  - A lone request is granted immediately regardless of the pointer.
- Not defined: fixed priority, where port 0 always wins and the pointer register is absent.

## Structure
- Package `dmem_arb_pkg`:
  - `typedef enum logic {PORT0, PORT1} port_e`
  - struct `mem_req_t` {addr, wdata, wen}
  - localparam `NUM_PORTS = 2`
- Sub-module `dmem_arb_sel`: the combinational grant logic (pointer-aware under the macro). The top level holds the response register, pointer and counter.

## Test plan
- Single read: port 0 reads 0x10 holding 0xDEADBEEF. Expect gnt0 in cycle N, rvalid0=1 and rdata0=0xDEADBEEF in N+1, rvalid1=0.
- Write then read: port 1 writes 0x1122334455667788 with wen=0x0F to 0x08, then reads 0x08. Expect rdata1 with the low 4 bytes updated.
- Conflict, fixed priority: both request for 3 cycles. Expect gnt0 each cycle, gnt1 only after req0 drops, `o_conflicts`=3.
- Conflict with `DMEM_ARB_RR_EN`: both request continuously. Expect grants alternating 0,1,0,1 and rvalids alternating one cycle later.
- Reset mid-read: assert `rst_n`=0 in the cycle after a read grant. Expect no rvalid, all outputs at reset values, counter 0.
- Saturation: with `CNT_WIDTH`=4, hold both requests for 20 cycles. Expect `o_conflicts`=15.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: port identifiers and the
// per-port memory request bundle.
package dmem_arb_pkg;

    localparam int unsigned NUM_PORTS     = 2;
    localparam int unsigned MEM_DATA_W    = 64;
    localparam int unsigned MEM_ADDR_W    = MEM_DATA_W;
    localparam int unsigned MEM_BYTES     = MEM_DATA_W / 8;

    typedef enum logic {PORT0, PORT1} port_e;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_BYTES-1:0]  wen;
    } mem_req_t;

endpackage

// File: rtl/dmem_arb_sel.sv
// Combinational grant selection for the two-port data-memory arbiter.
// DMEM_ARB_RR_EN selects round-robin on conflict; otherwise port 0 has fixed priority.
module dmem_arb_sel
    import dmem_arb_pkg::*;
(
    input  logic  en,
    input  logic  req0,
    input  logic  req1,
`ifdef DMEM_ARB_RR_EN
    input  port_e ptr,
`endif
    output logic  gnt0,
    output logic  gnt1
);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en) begin
`ifdef DMEM_ARB_RR_EN
            if (req0 && req1) begin
                gnt0 = (ptr == PORT0);
                gnt1 = (ptr == PORT1);
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
`else
            gnt0 = req0;
            gnt1 = req1 && !req0;
`endif
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported, synchronous-read data memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration (default: port 0 fixed priority).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = DATA_WIDTH,
    parameter int unsigned DATA_BYTES = DATA_WIDTH / 8,
    parameter int unsigned CNT_WIDTH  = 32
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req0,
    input  logic                  i_req1,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [DATA_WIDTH-1:0] i_wdata0,
    input  logic [DATA_WIDTH-1:0] i_wdata1,
    input  logic [DATA_BYTES-1:0] i_wen0,
    input  logic [DATA_BYTES-1:0] i_wen1,
    output logic                  o_gnt0,
    output logic                  o_gnt1,
    output logic                  o_rvalid0,
    output logic                  o_rvalid1,
    output logic [DATA_WIDTH-1:0] o_rdata0,
    output logic [DATA_WIDTH-1:0] o_rdata1,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [DATA_BYTES-1:0] o_mem_wen,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic [CNT_WIDTH-1:0]  o_conflicts
);

    logic                 gnt0;
    logic                 gnt1;
    logic                 resp_vld;
    port_e                resp_port;
    logic [CNT_WIDTH-1:0] conflicts;
`ifdef DMEM_ARB_RR_EN
    port_e                ptr;
`endif

    // rst_n gates the grant combinationally so nothing is accepted during reset
    dmem_arb_sel u_sel (
        .en   (rst_n),
        .req0 (i_req0),
        .req1 (i_req1),
`ifdef DMEM_ARB_RR_EN
        .ptr  (ptr),
`endif
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    assign o_gnt0 = gnt0;
    assign o_gnt1 = gnt1;

    always_comb begin
        o_mem_addr  = i_addr0;
        o_mem_wdata = i_wdata0;
        o_mem_wen   = '0;
        if (gnt0) begin
            o_mem_wen = i_wen0;
        end else if (gnt1) begin
            o_mem_addr  = i_addr1;
            o_mem_wdata = i_wdata1;
            o_mem_wen   = i_wen1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_vld  <= 1'b0;
            resp_port <= PORT0;
        end else begin
            resp_vld  <= (gnt0 && (i_wen0 == '0)) || (gnt1 && (i_wen1 == '0));
            resp_port <= gnt1 ? PORT1 : PORT0;
        end
    end

    // memory read data is already registered, so responses route it straight through
    assign o_rvalid0 = resp_vld && (resp_port == PORT0);
    assign o_rvalid1 = resp_vld && (resp_port == PORT1);
    assign o_rdata0  = o_rvalid0 ? i_mem_rdata : '0;
    assign o_rdata1  = o_rvalid1 ? i_mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflicts <= '0;
        end else if (i_req0 && i_req1 && !(&conflicts)) begin
            conflicts <= conflicts + CNT_WIDTH'(1);
        end
    end

    assign o_conflicts = conflicts;

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= PORT0;
        end else if (gnt0) begin
            ptr <= PORT1;
        end else if (gnt1) begin
            ptr <= PORT0;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, scoreboard-checked bench for dmem_arbiter (default and DMEM_ARB_RR_EN builds).
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    typedef struct {
        port_e       port;
        logic [63:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    mem_req_t    p0;
    mem_req_t    p1;

    logic        gnt0, gnt1, rv0, rv1;
    logic [63:0] rd0, rd1, mem_addr, mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic [7:0]  mem_wen;
    logic [31:0] conflicts;

    logic        s_gnt0, s_gnt1, s_rv0, s_rv1;
    logic [63:0] s_rd0, s_rd1, s_addr, s_wdata;
    logic [7:0]  s_wen;
    logic [3:0]  s_conflicts;

    logic [63:0] mem     [32];
    logic [63:0] ref_mem [32];
    resp_t       sbq[$];
    int unsigned m_cnt = 0;
    port_e       m_ptr = PORT0;
    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req0(req0), .i_req1(req1),
        .i_addr0(p0.addr), .i_addr1(p1.addr),
        .i_wdata0(p0.wdata), .i_wdata1(p1.wdata),
        .i_wen0(p0.wen), .i_wen1(p1.wen),
        .o_gnt0(gnt0), .o_gnt1(gnt1),
        .o_rvalid0(rv0), .o_rvalid1(rv1),
        .o_rdata0(rd0), .o_rdata1(rd1),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wen(mem_wen),
        .i_mem_rdata(mem_rdata),
        .o_conflicts(conflicts)
    );

    dmem_arbiter #(.CNT_WIDTH(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .i_req0(req0), .i_req1(req1),
        .i_addr0(p0.addr), .i_addr1(p1.addr),
        .i_wdata0(p0.wdata), .i_wdata1(p1.wdata),
        .i_wen0(p0.wen), .i_wen1(p1.wen),
        .o_gnt0(s_gnt0), .o_gnt1(s_gnt1),
        .o_rvalid0(s_rv0), .o_rvalid1(s_rv1),
        .o_rdata0(s_rd0), .o_rdata1(s_rd1),
        .o_mem_addr(s_addr), .o_mem_wdata(s_wdata), .o_mem_wen(s_wen),
        .i_mem_rdata(mem_rdata),
        .o_conflicts(s_conflicts)
    );

    // Synchronous-read, write-first memory behind the main DUT
    always @(posedge clk) begin
        logic [63:0] w;
        w = mem[mem_addr[7:3]];
        for (int b = 0; b < 8; b++)
            if (mem_wen[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        mem[mem_addr[7:3]] <= w;
        mem_rdata <= w;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_grant(input mem_req_t r, input port_e p);
        resp_t e;
        if (r.wen == '0) begin
            e.port = p;
            e.data = ref_mem[r.addr[7:3]];
            sbq.push_back(e);
        end else begin
            for (int b = 0; b < 8; b++)
                if (r.wen[b]) ref_mem[r.addr[7:3]][8*b +: 8] = r.wdata[8*b +: 8];
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        sbq.delete();
        m_cnt = 0;
        m_ptr = PORT0;
    endtask

    // Inputs are set just after a rising edge; checks run on the falling edge.
    task automatic cycle(input string tag);
        resp_t       r;
        logic        eg0, eg1, ev0, ev1;
        logic [63:0] ed0, ed1, ea, ew;
        logic [7:0]  ewen;
        @(negedge clk);
        ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
        if (sbq.size() > 0) begin
            r = sbq.pop_front();
            if (r.port == PORT0) begin ev0 = 1'b1; ed0 = r.data; end
            else begin ev1 = 1'b1; ed1 = r.data; end
        end
        chk({tag, ".rvalid0"}, rv0, ev0);
        chk({tag, ".rvalid1"}, rv1, ev1);
        chk({tag, ".rdata0"}, rd0, ed0);
        chk({tag, ".rdata1"}, rd1, ed1);
        eg0 = rst_n && req0 && (!req1 || m_ptr == PORT0);
        eg1 = rst_n && req1 && !eg0;
        chk({tag, ".gnt0"}, gnt0, eg0);
        chk({tag, ".gnt1"}, gnt1, eg1);
        ea   = eg1 ? p1.addr : p0.addr;
        ew   = eg1 ? p1.wdata : p0.wdata;
        ewen = eg0 ? p0.wen : (eg1 ? p1.wen : 8'h00);
        chk({tag, ".mem_addr"}, mem_addr, ea);
        chk({tag, ".mem_wdata"}, mem_wdata, ew);
        chk({tag, ".mem_wen"}, mem_wen, ewen);
        chk({tag, ".conflicts"}, conflicts, m_cnt);
        chk({tag, ".sat_conflicts"}, s_conflicts, (m_cnt > 15) ? 15 : m_cnt);
        if (eg0) model_grant(p0, PORT0);
        if (eg1) model_grant(p1, PORT1);
        if (rst_n && req0 && req1) m_cnt++;
`ifdef DMEM_ARB_RR_EN
        if (eg0) m_ptr = PORT1;
        else if (eg1) m_ptr = PORT0;
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i]     = 64'hC0DE_0000_0000_0000 | 64'(i);
            ref_mem[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
        end
        mem[2]     = 64'h0000_0000_DEAD_BEEF;
        ref_mem[2] = 64'h0000_0000_DEAD_BEEF;
        p0 = '{addr: 64'h0, wdata: 64'h0, wen: 8'h00};
        p1 = '{addr: 64'h0, wdata: 64'h0, wen: 8'h00};
        #1;

        // reset: grants forced low even with both requests up
        apply_reset();
        req0 = 1'b1; req1 = 1'b1;
        cycle("rst_a");
        cycle("rst_b");
        rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
        cycle("idle");

        // single read by port 0
        req0 = 1'b1; p0 = '{addr: 64'h10, wdata: 64'h0, wen: 8'h00};
        cycle("rd0");
        req0 = 1'b0;
        cycle("rd0_resp");

        // port 1 partial write then read-back of the same address
        req1 = 1'b1; p1 = '{addr: 64'h08, wdata: 64'h1122_3344_5566_7788, wen: 8'h0F};
        cycle("wr1");
        p1.wdata = '0; p1.wen = 8'h00;
        cycle("rd1");
        req1 = 1'b0;
        cycle("rd1_resp");

        // three-cycle conflict, then port 0 drops
        req0 = 1'b1; req1 = 1'b1;
        p0 = '{addr: 64'h18, wdata: 64'h0, wen: 8'h00};
        p1 = '{addr: 64'h20, wdata: 64'h0, wen: 8'h00};
        cycle("cf_1");
        cycle("cf_2");
        cycle("cf_3");
        req0 = 1'b0;
        cycle("cf_rel");
        req1 = 1'b0;
        cycle("cf_resp");

        // back-to-back cross-port traffic: response to one port alongside grant to the other
        req0 = 1'b1; p0 = '{addr: 64'h10, wdata: 64'h0, wen: 8'h00};
        cycle("bb_r0");
        req0 = 1'b0; req1 = 1'b1; p1 = '{addr: 64'h08, wdata: 64'h0, wen: 8'h00};
        cycle("bb_r1");
        req1 = 1'b0; req0 = 1'b1; p0 = '{addr: 64'h30, wdata: 64'hAAAA_BBBB_CCCC_DDDD, wen: 8'hF0};
        cycle("bb_w0");
        p0 = '{addr: 64'h30, wdata: 64'h0, wen: 8'h00};
        cycle("bb_r0b");
        req0 = 1'b0;
        cycle("bb_resp");

        // sim-control and cycle addresses pass through untouched
        req1 = 1'b1;
        p1.addr = 64'h40; cycle("sc_40");
        p1.addr = 64'h50; cycle("sc_50");
        p1.addr = 64'h60; cycle("cyc_60");
        req1 = 1'b0;
        cycle("sc_resp");

        // reset in the cycle after a read grant drops the response
        req0 = 1'b1; p0 = '{addr: 64'h10, wdata: 64'h0, wen: 8'h00};
        cycle("mr_gnt");
        req0 = 1'b0; req1 = 1'b1;
        apply_reset();
        cycle("mr_rst");
        rst_n = 1'b1; req1 = 1'b0;
        cycle("mr_post");

        // 20 conflict cycles: 32-bit counter reaches 20, 4-bit counter sticks at 15
        req0 = 1'b1; req1 = 1'b1;
        p0 = '{addr: 64'h18, wdata: 64'h0, wen: 8'h00};
        p1 = '{addr: 64'h20, wdata: 64'h0, wen: 8'h00};
        for (int i = 0; i < 20; i++) cycle("sat");
        req0 = 1'b0; req1 = 1'b0;
        cycle("sat_end");
        chk("sat_final", s_conflicts, 64'd15);
        chk("cnt_final", conflicts, 64'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
